// File: rtl/adc_lvds_capture.sv
// Capture stage behind the AD9643 LVDS front end: two-stage sample pipeline with
// optional offset-binary to two's-complement conversion and a per-channel test-pattern checker.
module adc_lvds_capture #(
  parameter int DATA_W   = 14,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     fmt_twos,
  input  logic                     chk_en,
  input  logic [1:0]               chk_mode,
  input  logic [DATA_W-1:0]        chk_pattern,
  input  logic                     err_clr,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        chk_locked,
  output logic [NUM_CH*CNT_W-1:0]  err_cnt
);

  localparam int RUN_W = $clog2(LOCK_CNT);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEEK, ST_LOCK} st_t;

  function automatic logic [NUM_CH*DATA_W-1:0] to_twos(input logic [NUM_CH*DATA_W-1:0] d,
                                                         input logic en);
    logic [NUM_CH*DATA_W-1:0] r;
    r = d;
    for (int c = 0; c < NUM_CH; c++) r[c*DATA_W+DATA_W-1] = d[c*DATA_W+DATA_W-1] ^ en;
    return r;
  endfunction

  // Reset asserts asynchronously; release is retimed to clk through two flops.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_ni;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_ni = rst_sync_q[1];

  logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [NUM_CH*DATA_W-1:0] data_p1_q, data_p1_d, data_p2_q, data_p2_d;
  logic [1:0]               mode_q, mode_d;
  logic                     active, mode_chg;

  always_comb begin
    vld_p1_d  = in_valid;
    data_p1_d = in_valid ? in_data : data_p1_q;
    vld_p2_d  = vld_p1_q;
    data_p2_d = vld_p1_q ? to_twos(data_p1_q, fmt_twos) : data_p2_q;
    mode_d    = chk_mode;
  end

  // stage 1: raw capture; stage 2: formatted output
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      mode_q    <= 2'd0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      data_p1_q <= data_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      mode_q    <= mode_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign active    = chk_en && (chk_mode != 2'd3);
  assign mode_chg  = chk_mode != mode_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chk
    st_t              st_q, st_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [DATA_W-1:0] exp_q, exp_d, smp;
    logic             seeded_q, seeded_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             match, is_pat, err_inc, locked;

    assign smp = data_p1_q[c*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
        st_q     <= ST_IDLE;
        run_q    <= '0;
        exp_q    <= '0;
        seeded_q <= 1'b0;
        err_q    <= '0;
      end else begin
        st_q     <= st_d;
        run_q    <= run_d;
        exp_q    <= exp_d;
        seeded_q <= seeded_d;
        err_q    <= err_d;
      end
    end

    always_comb begin
      st_d     = st_q;
      run_d    = run_q;
      exp_d    = exp_q;
      seeded_d = seeded_q;
      err_inc  = 1'b0;
      is_pat   = (smp == chk_pattern) || (smp == ~chk_pattern);
      case (chk_mode)
        2'd0:    match = smp == chk_pattern;
        2'd1:    match = !seeded_q || (smp == exp_q);
        2'd2:    match = seeded_q ? (smp == exp_q) : is_pat;
        default: match = 1'b0;
      endcase
      if (st_q == ST_IDLE) begin
        if (active) begin
          st_d     = ST_SEEK;
          run_d    = '0;
          seeded_d = 1'b0;
        end
      end else if (!active) begin
        st_d = ST_IDLE;
      end else if (mode_chg) begin
        st_d     = ST_SEEK;
        run_d    = '0;
        seeded_d = 1'b0;
      end else if (vld_p1_q) begin
        // Every valid sample re-seeds the expectation for the next one.
        exp_d    = (chk_mode == 2'd1) ? smp + DATA_W'(1) : ~smp;
        seeded_d = (chk_mode == 2'd1) || is_pat;
        if (st_q == ST_LOCK)       err_inc = !match;
        else if (!match)           run_d   = '0;
        else if (run_q == RUN_MAX) begin
          st_d  = ST_LOCK;
          run_d = '0;
        end else                   run_d   = run_q + RUN_W'(1);
      end
      if (err_clr)                                   err_d = '0;
      else if (err_inc && (err_q != {CNT_W{1'b1}}))  err_d = err_q + CNT_W'(1);
      else                                           err_d = err_q;
    end

    always_comb locked = (st_q == ST_LOCK);

    assign chk_locked[c]             = locked;
    assign err_cnt[c*CNT_W +: CNT_W] = err_q;
  end

endmodule

// File: tb/tb_adc_lvds_capture.sv
// Scoreboard bench for adc_lvds_capture: sample words are predicted into a queue at drive time,
// checker lock/error state comes from an arithmetic reference model updated each clock.
module tb_adc_lvds_capture;
  localparam int DW = 14, NC = 2, CW = 4, LC = 64;
  localparam int FULL = 1 << DW, MASK = FULL - 1, HALF = FULL / 2, CMAX = (1 << CW) - 1;
  localparam int P = 'h2AAA, NP = 'h1555;

  logic clk = 0, rst_n = 0, in_valid = 0, fmt_twos = 0, chk_en = 0, err_clr = 0;
  logic [NC*DW-1:0] in_data = '0;
  logic [1:0]       chk_mode = 2'd0;
  logic [DW-1:0]    chk_pattern = '0;
  logic             out_valid;
  logic [NC*DW-1:0] out_data;
  logic [NC-1:0]    chk_locked;
  logic [NC*CW-1:0] err_cnt;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  typedef struct { logic [NC*DW-1:0] d; int due; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [NC*DW-1:0] last_out = '0;

  // reference model state
  bit m_on[NC], m_lock[NC], m_have[NC], m_s1_vld, m_act, m_good, m_tw;
  int m_run[NC], m_last[NC], m_err[NC], m_s1[NC], m_s, m_pat, m_npat;
  logic [1:0] m_prev_mode;

  adc_lvds_capture #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CW), .LOCK_CNT(LC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .fmt_twos(fmt_twos),
    .chk_en(chk_en), .chk_mode(chk_mode), .chk_pattern(chk_pattern), .err_clr(err_clr),
    .out_valid(out_valid), .out_data(out_data), .chk_locked(chk_locked), .err_cnt(err_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NC*DW-1:0] pk(input int a1, input int a0);
    return {DW'(a1), DW'(a0)};
  endfunction

  // Two's complement of an offset-binary code is the code minus half scale.
  function automatic logic [NC*DW-1:0] to_out(input logic [NC*DW-1:0] d, input bit twos);
    logic [NC*DW-1:0] r;
    int v;
    for (int c = 0; c < NC; c++) begin
      v = int'(d[c*DW +: DW]);
      if (twos) v = (v - HALF + FULL) % FULL;
      r[c*DW +: DW] = DW'(v);
    end
    return r;
  endfunction

  function automatic int bad_word(input int p);
    return p ^ int'($urandom_range(1, MASK));
  endfunction

  // Reference model of the pattern checkers, fed from the stage-1 copy of the inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) begin
        m_on[c] = 0; m_lock[c] = 0; m_run[c] = 0; m_have[c] = 0;
        m_last[c] = 0; m_err[c] = 0; m_s1[c] = 0;
      end
      m_s1_vld = 0;
      m_prev_mode = 2'd0;
    end else begin
      m_act = chk_en && (chk_mode != 2'd3);
      for (int c = 0; c < NC; c++) begin
        m_s    = m_s1[c];
        m_pat  = int'(chk_pattern);
        m_npat = m_pat ^ MASK;
        m_tw   = (m_s == m_pat) || (m_s == m_npat);
        case (chk_mode)
          2'd0:    m_good = (m_s == m_pat);
          2'd1:    m_good = !m_have[c] || (m_s == (m_last[c] + 1) % FULL);
          default: m_good = m_have[c] ? (m_s == (m_last[c] ^ MASK)) : m_tw;
        endcase
        if (!m_on[c]) begin
          if (m_act) begin m_on[c] = 1; m_run[c] = 0; m_have[c] = 0; end
        end else if (!m_act) begin
          m_on[c] = 0; m_lock[c] = 0;
        end else if (chk_mode != m_prev_mode) begin
          m_lock[c] = 0; m_run[c] = 0; m_have[c] = 0;
        end else if (m_s1_vld) begin
          if (m_lock[c]) begin
            if (!m_good && m_err[c] < CMAX) m_err[c]++;
          end else if (m_good) begin
            m_run[c]++;
            if (m_run[c] == LC) m_lock[c] = 1;
          end else m_run[c] = 0;
          m_last[c] = m_s;
          m_have[c] = (chk_mode == 2'd1) || m_tw;
        end
        if (err_clr) m_err[c] = 0;
      end
      m_prev_mode = chk_mode;
      m_s1_vld = in_valid;
      for (int c = 0; c < NC; c++) m_s1[c] = int'(in_data[c*DW +: DW]);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a sample.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: got 0x%0h, expected no sample (cycle %0d)", out_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(mon_e.d));
          check("latency", 32'(cyc), 32'(mon_e.due));
          last_out = mon_e.d;
        end
      end else check("out_hold", 32'(out_data), 32'(last_out));
      check("chk_locked", 32'(chk_locked), 32'({m_lock[1], m_lock[0]}));
      check("err_cnt", 32'(err_cnt), 32'({CW'(m_err[1]), CW'(m_err[0])}));
    end
  end

  task automatic drive(input bit v, input logic [NC*DW-1:0] d, input bit clr);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_data = d; err_clr = clr;
    if (v) begin
      e.d = to_out(d, fmt_twos);
      e.due = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, (NC*DW)'($urandom), 0);
  endtask

  task automatic set_fmt(input bit v);
    idle(3);
    fmt_twos = v;
  endtask

  task automatic ramp(input int s0, input int s1, input int n);
    for (int i = 0; i < n; i++) drive(1, pk((s1 + i) % FULL, (s0 + i) % FULL), 0);
  endtask

  task automatic chk_status(input string name, input logic [NC-1:0] lk, input int e1, input int e0);
    check({name, "_locked"}, 32'(chk_locked), 32'(lk));
    check({name, "_err"}, 32'(err_cnt), 32'({CW'(e1), CW'(e0)}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1, s0, s1, pat;
    bit v;
    fmt_twos = 1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_data", 32'(out_data), 0);
    chk_status("reset", 2'b00, 0, 0);
    rst_n = 1;
    idle(4);

    // format path
    drive(1, pk('h1FFF, 'h2000), 0);
    drive(0, '0, 0);
    check("fmt_early_valid", 32'(out_valid), 0);
    drive(0, '0, 0);
    check("fmt_twos_valid", 32'(out_valid), 1);
    check("fmt_twos_data", 32'(out_data), 32'(pk('h3FFF, 'h0000)));
    set_fmt(0);
    drive(1, pk('h1FFF, 'h2000), 0);
    idle(2);
    check("fmt_pass_data", 32'(out_data), 32'(pk('h1FFF, 'h2000)));
    for (int g = 0; g < 4; g++) begin
      set_fmt(1'($urandom_range(0, 1)));
      for (int i = 0; i < 10; i++) drive(1'($urandom_range(0, 1)), (NC*DW)'($urandom), 0);
    end

    // ramp lock across the 14-bit wrap
    set_fmt(1'($urandom_range(0, 1)));
    chk_en = 1; chk_mode = 2'd1;
    ramp('h3FC0, int'($urandom_range(0, MASK)), 100);
    idle(3);
    chk_status("ramp", 2'b11, 0, 0);

    // fixed pattern, errors on ch1 only, then saturation
    chk_mode = 2'd0; chk_pattern = DW'(P);
    for (int i = 0; i < 70; i++) drive(1, pk(P, P), 0);
    for (int i = 0; i < 18; i++) drive(1, pk((i % 6 == 2) ? bad_word(P) : P, P), 0);
    idle(3);
    chk_status("fixed_3err", 2'b11, 3, 0);
    for (int i = 0; i < 20; i++) drive(1, pk(bad_word(P), P), 0);
    idle(3);
    chk_status("saturate", 2'b11, CMAX, 0);

    // err_clr alone, then colliding with a mismatch
    drive(0, '0, 1);
    idle(2);
    chk_status("err_clr", 2'b11, 0, 0);
    drive(1, pk(bad_word(P), P), 0);
    idle(3);
    chk_status("one_err", 2'b11, 1, 0);
    drive(1, pk(bad_word(P), P), 0);
    drive(1, pk(P, P), 1);
    drive(1, pk(P, P), 0);
    idle(3);
    chk_status("clr_priority", 2'b11, 0, 0);

    // mode change while locked keeps the counts
    drive(1, pk(bad_word(P), P), 0);
    drive(1, pk(P, P), 0);
    drive(1, pk(bad_word(P), P), 0);
    idle(3);
    chk_mode = 2'd2;
    idle(1);
    chk_status("mode_change", 2'b00, 2, 0);

    // toggle with bubbles
    for (int i = 0; i < 70; i++) begin
      drive(1, pk((i % 2) ? P : NP, (i % 2) ? NP : P), 0);
      drive(0, (NC*DW)'($urandom), 0);
    end
    idle(3);
    chk_status("toggle", 2'b11, 2, 0);

    chk_en = 0;
    idle(1);
    chk_status("chk_en_off", 2'b00, 2, 0);

    // asynchronous reset in the middle of a ramp
    chk_en = 1; chk_mode = 2'd1;
    ramp(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 80);
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_data", 32'(out_data), 0);
    chk_status("arst", 2'b00, 0, 0);
    sb.delete();
    last_out = '0;
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle(4);
    s0 = int'($urandom_range(0, MASK)); s1 = int'($urandom_range(0, MASK));
    ramp(s0, s1, 63);
    idle(3);
    chk_status("relock_63", 2'b00, 0, 0);
    ramp((s0 + 63) % FULL, (s1 + 63) % FULL, 10);
    idle(3);
    chk_status("relock", 2'b11, 0, 0);

    // randomized fixed-pattern traffic with noise, bubbles and clears
    pat = int'($urandom_range(0, MASK));
    chk_mode = 2'd0; chk_pattern = DW'(pat);
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      w0 = (i > 120 && $urandom_range(0, 31) == 0) ? bad_word(pat) : pat;
      w1 = (i > 120 && $urandom_range(0, 15) == 0) ? bad_word(pat) : pat;
      drive(v, pk(w1, w0), ($urandom_range(0, 63) == 0));
    end
    idle(4);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
